cache_mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches, between their memory-side request ports and the single shared memory bus.
- Arbitrates per-word transactions from the read-only I-side and the read/write D-side.
- Locks the grant for a whole cache-line burst (refill or writeback) so beats of different lines never interleave.
- Round-robin between the two caches; one beat outstanding at a time.

---
 rtl/cache_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shared memory-bus arbiter for the I- and D-cache memory ports.
// Grants are held for a whole cache-line burst; one beat is in flight at a time.
module cache_mem_arbiter #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned CPU_WIDTH  = 32,
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    // I-cache side (read only)
    input  logic                   i_mem_ce,
    input  logic [BUS_WIDTH-1:0]   i_mem_addr,
    output logic [CPU_WIDTH-1:0]   i_mem_rdata,
    output logic                   i_mem_rdata_valid,
    // D-cache side
    input  logic                   d_mem_ce,
    input  logic                   d_mem_we,
    input  logic [BUS_WIDTH-1:0]   d_mem_addr,
    input  logic [CPU_WIDTH-1:0]   d_mem_wdata,
    input  logic [CPU_WIDTH/8-1:0] d_mem_wmask,
    output logic [CPU_WIDTH-1:0]   d_mem_rdata,
    output logic                   d_mem_rdata_valid,
    output logic                   d_mem_write_respone,
    // Shared memory bus
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [BUS_WIDTH-1:0]   bus_addr,
    output logic [CPU_WIDTH-1:0]   bus_wdata,
    output logic [CPU_WIDTH/8-1:0] bus_wmask,
    input  logic                   bus_ready,
    input  logic [CPU_WIDTH-1:0]   bus_rdata,
    input  logic                   bus_rvalid,
    input  logic                   bus_bresp
);

    localparam int unsigned CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             last_q, last_d;  // 0 = I served last, 1 = D served last

    logic grant_i;
    logic grant_d;
    logic port_ce;
    logic accept;
    logic done;

    assign grant_i = (state_q == GNT_I);
    assign grant_d = (state_q == GNT_D);
    assign port_ce = (grant_i & i_mem_ce) | (grant_d & d_mem_ce);
    assign accept  = bus_req & bus_ready;
    // Responses only count while a beat is actually outstanding.
    assign done    = pend_q & (bus_rvalid | bus_bresp) & (grant_i | grant_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie the port that was not served last wins.
                if (d_mem_ce && (!i_mem_ce || !last_q)) begin
                    state_d = GNT_D;
                end else if (i_mem_ce) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (done) begin
                    pend_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        last_d  = grant_d;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (accept) begin
                    pend_d = 1'b1;
                end else if (!pend_q && !port_ce) begin
                    // Granted cache went quiet between beats: release the bus.
                    state_d = IDLE;
                    cnt_d   = '0;
                    last_d  = grant_d;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus_req   = port_ce & ~pend_q;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wmask = '0;
        case (state_q)
            GNT_I: begin
                bus_addr = i_mem_addr;
            end
            GNT_D: begin
                bus_we    = d_mem_we;
                bus_addr  = d_mem_addr;
                bus_wdata = d_mem_wdata;
                bus_wmask = d_mem_wmask;
            end
            default: begin
                bus_addr = '0;
            end
        endcase
    end

    assign i_mem_rdata         = grant_i ? bus_rdata : '0;
    assign i_mem_rdata_valid   = grant_i & pend_q & bus_rvalid;
    assign d_mem_rdata         = grant_d ? bus_rdata : '0;
    assign d_mem_rdata_valid   = grant_d & pend_q & bus_rvalid;
    assign d_mem_write_respone = grant_d & pend_q & bus_bresp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: per-cycle vector table plus burst sequences.
module tb_cache_mem_arbiter;

    localparam int BW = 32;
    localparam int CW = 32;
    localparam int LW = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_mem_ce;
    logic [BW-1:0]   i_mem_addr;
    logic [CW-1:0]   i_mem_rdata;
    logic            i_mem_rdata_valid;
    logic            d_mem_ce;
    logic            d_mem_we;
    logic [BW-1:0]   d_mem_addr;
    logic [CW-1:0]   d_mem_wdata;
    logic [CW/8-1:0] d_mem_wmask;
    logic [CW-1:0]   d_mem_rdata;
    logic            d_mem_rdata_valid;
    logic            d_mem_write_respone;
    logic            bus_req;
    logic            bus_we;
    logic [BW-1:0]   bus_addr;
    logic [CW-1:0]   bus_wdata;
    logic [CW/8-1:0] bus_wmask;
    logic            bus_ready;
    logic [CW-1:0]   bus_rdata;
    logic            bus_rvalid;
    logic            bus_bresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .BUS_WIDTH (BW),
        .CPU_WIDTH (CW),
        .LINE_WORDS(LW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_mem_ce           (i_mem_ce),
        .i_mem_addr         (i_mem_addr),
        .i_mem_rdata        (i_mem_rdata),
        .i_mem_rdata_valid  (i_mem_rdata_valid),
        .d_mem_ce           (d_mem_ce),
        .d_mem_we           (d_mem_we),
        .d_mem_addr         (d_mem_addr),
        .d_mem_wdata        (d_mem_wdata),
        .d_mem_wmask        (d_mem_wmask),
        .d_mem_rdata        (d_mem_rdata),
        .d_mem_rdata_valid  (d_mem_rdata_valid),
        .d_mem_write_respone(d_mem_write_respone),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_wmask          (bus_wmask),
        .bus_ready          (bus_ready),
        .bus_rdata          (bus_rdata),
        .bus_rvalid         (bus_rvalid),
        .bus_bresp          (bus_bresp)
    );

    typedef struct packed {
        logic        rst, ice, dce, dwe, rdy, rv, br;
        logic        req, we;
        logic [31:0] addr;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic        iv, dv, wr;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs change at the negedge; outputs are sampled 1 time unit later.
    task automatic idle_chk(input string name);
        #1;
        chk(name, {bus_req, bus_we, bus_addr, bus_wmask}, '0);
        @(negedge clk);
    endtask

    task automatic beat(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int stall);
        bus_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            #1;
            chk("stall_req", bus_req, 1);
            chk("stall_addr", bus_addr, addr);
            @(negedge clk);
        end
        bus_ready = 1'b1;
        #1;
        chk("acc_req", bus_req, 1);
        chk("acc_addr", bus_addr, addr);
        chk("acc_we", bus_we, we);
        if (is_d && we) chk("acc_wdata", bus_wdata, wd);
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        chk("pend_req", bus_req, 0);
        @(negedge clk);
        bus_rdata  = rd;
        bus_rvalid = !we;
        bus_bresp  = we;
        #1;
        chk("i_valid", i_mem_rdata_valid, !is_d);
        chk("d_valid", d_mem_rdata_valid, is_d && !we);
        chk("d_wresp", d_mem_write_respone, is_d && we);
        if (!we) chk("rdata", is_d ? d_mem_rdata : i_mem_rdata, rd);
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_bresp  = 1'b0;
    endtask

    vec_t vecs[18];
    vec_t v;

    initial begin
        //           rst ice dce dwe rdy rv br  req we addr          wm    wd            iv dv wr
        vecs[0]  = '{H, H, H, L, L, L, L,  L, L, 32'h0,    4'h0, 32'h0,        L, L, L};
        vecs[1]  = '{L, H, H, L, L, L, L,  L, L, 32'h0,    4'h0, 32'h0,        L, L, L};
        vecs[2]  = '{L, H, H, L, H, L, L,  H, L, 32'h2000, 4'h3, 32'hCAFE0001, L, L, L};
        vecs[3]  = '{L, H, H, L, H, L, L,  L, L, 32'h2000, 4'h3, 32'hCAFE0001, L, L, L};
        vecs[4]  = '{L, H, H, L, L, H, L,  L, L, 32'h2000, 4'h3, 32'hCAFE0001, L, H, L};
        vecs[5]  = '{L, H, L, L, L, L, L,  L, L, 32'h2000, 4'h3, 32'hCAFE0001, L, L, L};
        vecs[6]  = '{L, H, H, L, L, L, L,  L, L, 32'h0,    4'h0, 32'h0,        L, L, L};
        vecs[7]  = '{L, H, H, L, L, L, L,  H, L, 32'h1000, 4'h0, 32'h0,        L, L, L};
        vecs[8]  = '{L, H, H, L, H, L, L,  H, L, 32'h1000, 4'h0, 32'h0,        L, L, L};
        vecs[9]  = '{L, H, H, L, L, H, L,  L, L, 32'h1000, 4'h0, 32'h0,        H, L, L};
        vecs[10] = '{L, H, H, L, L, H, L,  H, L, 32'h1000, 4'h0, 32'h0,        L, L, L};
        vecs[11] = '{L, L, H, L, L, L, L,  L, L, 32'h1000, 4'h0, 32'h0,        L, L, L};
        vecs[12] = '{L, L, H, H, L, L, L,  L, L, 32'h0,    4'h0, 32'h0,        L, L, L};
        vecs[13] = '{L, L, H, H, H, L, L,  H, H, 32'h2000, 4'h3, 32'hCAFE0001, L, L, L};
        vecs[14] = '{L, L, H, H, L, L, H,  L, H, 32'h2000, 4'h3, 32'hCAFE0001, L, L, H};
        vecs[15] = '{L, L, H, H, L, L, H,  H, H, 32'h2000, 4'h3, 32'hCAFE0001, L, L, L};
        vecs[16] = '{H, L, H, H, L, L, L,  H, H, 32'h2000, 4'h3, 32'hCAFE0001, L, L, L};
        vecs[17] = '{L, L, L, L, L, L, L,  L, L, 32'h0,    4'h0, 32'h0,        L, L, L};

        reset = 1'b1;
        i_mem_ce = 1'b0; i_mem_addr = 32'h1000;
        d_mem_ce = 1'b0; d_mem_we = 1'b0; d_mem_addr = 32'h2000;
        d_mem_wdata = 32'hCAFE0001; d_mem_wmask = 4'h3;
        bus_ready = 1'b0; bus_rdata = 32'hDEADBEEF; bus_rvalid = 1'b0; bus_bresp = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; i_mem_ce = v.ice; d_mem_ce = v.dce; d_mem_we = v.dwe;
            bus_ready = v.rdy; bus_rvalid = v.rv; bus_bresp = v.br;
            #1;
            chk($sformatf("vec%0d", i),
                {bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
                 i_mem_rdata_valid, d_mem_rdata_valid, d_mem_write_respone},
                {v.req, v.we, v.addr, v.wm, v.wd, v.iv, v.dv, v.wr});
        end
        @(negedge clk);

        // Tie straight out of reset: D line first, then I line.
        reset = 1'b1; i_mem_ce = 1'b0; d_mem_ce = 1'b0; d_mem_we = 1'b0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_bresp = 1'b0;
        @(negedge clk);
        reset = 1'b0; i_mem_ce = 1'b1; d_mem_ce = 1'b1;
        idle_chk("tie_idle");
        for (int n = 0; n < LW; n++) begin
            d_mem_addr = 32'h2000 + 32'(4 * n);
            beat(1'b1, 1'b0, d_mem_addr, 32'h0, 32'hD000 + 32'(n), 0);
        end
        idle_chk("d_burst_end");
        for (int n = 0; n < LW; n++) begin
            i_mem_addr = 32'h1000 + 32'(4 * n);
            beat(1'b0, 1'b0, i_mem_addr, 32'h0, 32'hA000 + 32'(n), 0);
        end
        i_mem_ce = 1'b0; d_mem_ce = 1'b0;
        idle_chk("i_burst_end");

        // Writeback with backpressure on beat 3; I arrives mid-line.
        d_mem_ce = 1'b1; d_mem_we = 1'b1; d_mem_wmask = 4'hF;
        idle_chk("wb_idle");
        for (int n = 0; n < LW; n++) begin
            d_mem_addr  = 32'h3000 + 32'(4 * n);
            d_mem_wdata = 32'h100 + 32'(n);
            if (n == 8) begin
                i_mem_ce = 1'b1; i_mem_addr = 32'h1100;
            end
            beat(1'b1, 1'b1, d_mem_addr, 32'h100 + 32'(n), 32'h0, (n == 3) ? 5 : 0);
        end
        d_mem_we = 1'b0;
        idle_chk("wb_end");
        for (int n = 0; n < 2; n++) begin
            i_mem_addr = 32'h1100 + 32'(4 * n);
            beat(1'b0, 1'b0, i_mem_addr, 32'h0, 32'hB000 + 32'(n), 0);
        end
        i_mem_ce = 1'b0;
        #1; chk("i_release_req", bus_req, 0);
        @(negedge clk);
        idle_chk("rr_idle");
        for (int n = 0; n < 4; n++) begin
            d_mem_addr = 32'h3000 + 32'(4 * n);
            beat(1'b1, 1'b0, d_mem_addr, 32'h0, 32'hC000 + 32'(n), 0);
        end

        // Early release by D after 4 beats; waiting I gets the next grant.
        d_mem_ce = 1'b0; i_mem_ce = 1'b1; i_mem_addr = 32'h1200;
        #1; chk("d_release_req", bus_req, 0);
        @(negedge clk);
        idle_chk("early_idle");
        for (int n = 0; n < LW; n++) begin
            i_mem_addr = 32'h1200 + 32'(4 * n);
            beat(1'b0, 1'b0, i_mem_addr, 32'h0, 32'hE000 + 32'(n), 0);
        end
        idle_chk("i_refill_end");
        i_mem_ce = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset while beat 7 is outstanding; late response must be dropped.
        d_mem_ce = 1'b1; d_mem_we = 1'b0;
        idle_chk("rst_idle");
        for (int n = 0; n < 7; n++) begin
            d_mem_addr = 32'h4000 + 32'(4 * n);
            beat(1'b1, 1'b0, d_mem_addr, 32'h0, 32'hF000 + 32'(n), 0);
        end
        d_mem_addr = 32'h401C;
        bus_ready = 1'b1;
        #1; chk("rst_acc_req", bus_req, 1);
        @(negedge clk);
        bus_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA;
        #1;
        chk("post_rst_outs",
            {bus_req, bus_addr, d_mem_rdata_valid, i_mem_rdata_valid, d_mem_write_respone}, '0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1; chk("post_rst_req", bus_req, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
